mask16_accum: RTL and testbench

- Sequential consumer stage placed directly downstream of the 16-bit bitwise AND datapath.
- Accepts a stream of operand pairs over a valid/ready handshake and forms the per-beat mask a&b.
- Reduces each packet of masks, with packet end marked by in_last, into a running AND, a running OR and a beat count.
- Presents the packet result on a valid/ready output port.

---
 rtl/mask16_accum.sv | 122 ++++++++++++
 tb/tb_mask16_accum.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mask16_accum.sv
`default_nettype none
// ============================================================================
// Module      : mask16_accum
// Description : Reduces packets of per-beat masks (a & b) into running AND/OR
//               and a saturating beat count, presented over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module mask16_accum #(
    parameter int WIDTH     = 16,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_and,
    output logic [WIDTH-1:0] out_or,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_and;
    logic [WIDTH-1:0] r_or;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_take;
    logic [WIDTH-1:0] w_prod;

    assign w_accept = in_valid && r_in_ready;
    assign w_take   = r_out_valid && out_ready;
    assign w_prod   = in_a & in_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_and       <= '0;
            r_or        <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // in_ready first rises here, one edge after reset release
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_and   <= w_prod;
                        r_or    <= w_prod;
                        r_count <= c_one;
                        r_ovf   <= 1'b0;
                        if (in_last) begin
                            r_state     <= HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        r_and <= r_and & w_prod;
                        r_or  <= r_or | w_prod;
                        if (r_count < c_max) begin
                            r_count <= r_count + c_one;
                        end else begin
                            r_ovf <= 1'b1;
                        end
                        if (in_last) begin
                            r_state     <= HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // in_ready stays low during the take cycle, so no beat slips in
                    if (w_take) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_and      = r_and;
    assign out_or       = r_or;
    assign out_count    = r_count;
    assign out_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mask16_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_mask16_accum
// Description : Self-checking bench for mask16_accum (vectors, corner cases,
//               randomized packets against a reduction model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mask16_accum;

    localparam int WIDTH     = 16;
    localparam int MAX_BEATS = 16;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_and;
    logic [WIDTH-1:0] out_or;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    mask16_accum #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_and     (out_and),
        .out_or      (out_or),
        .out_count   (out_count),
        .out_overflow(out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              n;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [15:0]     ea;
        logic [15:0]     eo;
        int              ec;
    } vec_t;

    vec_t vt [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        while (!in_ready && k < 200) begin
            tick();
            k++;
        end
        if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic expect_res(input string nm, input logic [15:0] ea, input logic [15:0] eo,
                              input int ec, input logic eov, input int hold);
        int k;
        k = 0;
        while (!out_valid && k < 200) begin
            tick();
            k++;
        end
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        for (int h = 0; h <= hold; h++) begin
            chk({nm, "_in_ready_low"}, 32'(in_ready), 32'd0);
            chk({nm, "_and"}, 32'(out_and), 32'(ea));
            chk({nm, "_or"}, 32'(out_or), 32'(eo));
            chk({nm, "_count"}, 32'(out_count), 32'(ec));
            chk({nm, "_ovf"}, 32'(out_overflow), 32'(eov));
            if (h < hold) tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, "_taken"}, 32'(out_valid), 32'd0);
        chk({nm, "_ready_after_take"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] ra, rb, p, ma, mo;
        int          n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        vt[0].n = 1; vt[0].a[0] = 16'h0001; vt[0].b[0] = 16'h0001;
        vt[0].ea = 16'h0001; vt[0].eo = 16'h0001; vt[0].ec = 1;
        vt[1].n = 3;
        vt[1].a[0] = 16'hFFFF; vt[1].b[0] = 16'h00FF;
        vt[1].a[1] = 16'h0F0F; vt[1].b[1] = 16'hFFFF;
        vt[1].a[2] = 16'hFF00; vt[1].b[2] = 16'hFFFF;
        vt[1].ea = 16'h0000; vt[1].eo = 16'hFFFF; vt[1].ec = 3;
        vt[2].n = 2;
        vt[2].a[0] = 16'hF0F0; vt[2].b[0] = 16'hFFFF;
        vt[2].a[1] = 16'hFFFF; vt[2].b[1] = 16'h0FF0;
        vt[2].ea = 16'h00F0; vt[2].eo = 16'hFFF0; vt[2].ec = 2;
        vt[3].n = 1; vt[3].a[0] = 16'h1234; vt[3].b[0] = 16'h0000;
        vt[3].ea = 16'h0000; vt[3].eo = 16'h0000; vt[3].ec = 1;

        // Reset values
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_and", 32'(out_and), 32'd0);
        chk("rst_or", 32'(out_or), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_ovf", 32'(out_overflow), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        chk("release_in_ready_high", 32'(in_ready), 32'd1);

        // Single beat: result visible in the very next cycle
        send(16'h0001, 16'h0001, 1'b1);
        chk("single_latency", 32'(out_valid), 32'd1);
        expect_res("single", 16'h0001, 16'h0001, 1, 1'b0, 0);

        // Table vectors
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < vt[v].n; i++)
                send(vt[v].a[i], vt[v].b[i], i == vt[v].n - 1);
            expect_res($sformatf("vec%0d", v), vt[v].ea, vt[v].eo, vt[v].ec, 1'b0, 1);
        end

        // Backpressure with a pending beat
        send(16'h0001, 16'h0001, 1'b1);
        in_valid = 1'b1; in_a = 16'h00F0; in_b = 16'h0FF0; in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_and", 32'(out_and), 32'h0001);
            chk("bp_count", 32'(out_count), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_taken", 32'(out_valid), 32'd0);
        chk("bp_ready_next", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_fresh_valid", 32'(out_valid), 32'd1);
        expect_res("bp_fresh", 16'h00F0, 16'h00F0, 1, 1'b0, 0);

        // Overflow, then cleared by the next packet
        for (int i = 0; i < 18; i++) send(16'hFFFF, 16'hFFFF, i == 17);
        expect_res("ovf", 16'hFFFF, 16'hFFFF, 16, 1'b1, 1);
        send(16'h0F0F, 16'h00FF, 1'b1);
        expect_res("ovf_clear", 16'h000F, 16'h000F, 1, 1'b0, 0);

        // Exactly MAX_BEATS beats: saturates without overflow
        for (int i = 0; i < 16; i++) send(16'hFFFF, 16'hFFFF, i == 15);
        expect_res("max_exact", 16'hFFFF, 16'hFFFF, 16, 1'b0, 0);

        // Reset mid-packet
        send(16'hFFFF, 16'hFFFF, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_and", 32'(out_and), 32'd0);
        chk("midrst_or", 32'(out_or), 32'd0);
        chk("midrst_count", 32'(out_count), 32'd0);
        chk("midrst_ovf", 32'(out_overflow), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send(16'h00F0, 16'h0FF0, 1'b1);
        expect_res("post_rst", 16'h00F0, 16'h00F0, 1, 1'b0, 0);

        // Gaps between beats
        for (int i = 0; i < 3; i++) begin
            send(vt[1].a[i], vt[1].b[i], i == 2);
            if (i < 2) begin
                tick(); tick();
            end
        end
        expect_res("gaps", 16'h0000, 16'hFFFF, 3, 1'b0, 0);

        // Randomized packets against a reduction model
        for (int pk = 0; pk < 40; pk++) begin
            n  = $urandom_range(1, 20);
            ma = 16'hFFFF;
            mo = 16'h0000;
            for (int i = 0; i < n; i++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                p  = ra & rb;
                ma = ma & p;
                mo = mo | p;
                send(ra, rb, i == n - 1);
                if (i < n - 1) begin
                    for (int g = $urandom_range(0, 2); g > 0; g--) tick();
                end
            end
            expect_res($sformatf("rand%0d", pk), ma, mo, (n > MAX_BEATS) ? MAX_BEATS : n,
                       n > MAX_BEATS, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
